// File: rtl/fifo_s8_to_s16_if.sv
// Byte-write / word-read FIFO bus plus the mixed-width RAM port bundle.
// master drives requests and RAM read data; slave is the FIFO controller.
interface fifo_s8_to_s16_if;
  logic        FLUSH;
  logic        WR_EN;
  logic [7:0]  DIN;
  logic        FULL;
  logic        AFULL;
  logic        RD_EN;
  logic [15:0] DOUT;
  logic        DOUT_VALID;
  logic        EMPTY;
  logic        AEMPTY;
  logic [9:0]  BYTE_COUNT;
  logic        OVERFLOW;
  logic        UNDERFLOW;
  logic        RAM_ENA;
  logic        RAM_WEA;
  logic [8:0]  RAM_ADDRA;
  logic [7:0]  RAM_DIA;
  logic        RAM_ENB;
  logic [7:0]  RAM_ADDRB;
  logic [15:0] RAM_DOB;

  modport master (
    output FLUSH, WR_EN, DIN, RD_EN, RAM_DOB,
    input  FULL, AFULL, DOUT, DOUT_VALID, EMPTY, AEMPTY,
    input  BYTE_COUNT, OVERFLOW, UNDERFLOW,
    input  RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DIA,
    input  RAM_ENB, RAM_ADDRB
  );

  modport slave (
    input  FLUSH, WR_EN, DIN, RD_EN, RAM_DOB,
    output FULL, AFULL, DOUT, DOUT_VALID, EMPTY, AEMPTY,
    output BYTE_COUNT, OVERFLOW, UNDERFLOW,
    output RAM_ENA, RAM_WEA, RAM_ADDRA, RAM_DIA,
    output RAM_ENB, RAM_ADDRB
  );
endinterface

// File: rtl/fifo_s8_to_s16.sv
// FIFO controller packing an 8-bit write stream into 16-bit reads
// over a 512x8 / 256x16 mixed-width dual-port block RAM.
module fifo_s8_to_s16 #(
  parameter int unsigned AFULL_THRESH  = 448,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input logic             CLK,
  input logic             RST,
  fifo_s8_to_s16_if.slave bus
);

  localparam logic [9:0] AF_T = 10'(AFULL_THRESH);
  localparam logic [8:0] AE_T = 9'(AEMPTY_THRESH);

  logic [9:0] wp_q, wp_d;
  logic [8:0] rp_q, rp_d;
  logic [9:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       afull_q, afull_d;
  logic       aempty_q, aempty_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       dv_q, dv_d;
  logic       wa, ra;

  assign wa = bus.WR_EN & ~full_q & ~bus.FLUSH;
  assign ra = bus.RD_EN & ~empty_q & ~bus.FLUSH;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (bus.FLUSH) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (wa) wp_d = wp_q + 10'd1;
      if (ra) rp_d = rp_q + 9'd1;
    end
    // Wrap bits make the modulo-1024 difference exact for 0..512.
    cnt_d    = wp_d - {rp_d, 1'b0};
    full_d   = cnt_d[9];
    empty_d  = (cnt_d < 10'd2);
    afull_d  = (cnt_d >= AF_T);
    aempty_d = (cnt_d[9:1] <= AE_T);
    ovf_d    = ~bus.FLUSH & (ovf_q | (bus.WR_EN & full_q));
    unf_d    = ~bus.FLUSH & (unf_q | (bus.RD_EN & empty_q));
    dv_d     = ra;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dv_q     <= dv_d;
    end
  end

  assign bus.FULL       = full_q;
  assign bus.EMPTY      = empty_q;
  assign bus.AFULL      = afull_q;
  assign bus.AEMPTY     = aempty_q;
  assign bus.BYTE_COUNT = cnt_q;
  assign bus.OVERFLOW   = ovf_q;
  assign bus.UNDERFLOW  = unf_q;
  assign bus.DOUT_VALID = dv_q;
  assign bus.DOUT       = dv_q ? bus.RAM_DOB : 16'h0000;

  assign bus.RAM_ENA   = wa & ~RST;
  assign bus.RAM_WEA   = wa & ~RST;
  assign bus.RAM_ADDRA = wp_q[8:0];
  assign bus.RAM_DIA   = bus.DIN;
  assign bus.RAM_ENB   = ra & ~RST;
  assign bus.RAM_ADDRB = rp_q[7:0];

endmodule
